// File: rtl/alarm_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_sequencer
//   Turns a time-of-day match into a ring episode. The episode is a series
//   of one-cycle set pulses to the alert player, spaced BEEP_PERIOD seconds
//   apart. It supports snooze and stop requests and times out by itself
//   after MAX_BEEPS pulses.
//
// Parameters
//   BEEP_PERIOD  seconds between set pulses while ringing (1..15)
//   MAX_BEEPS    set pulses per ring episode before auto-timeout (1..15)
//   SNOOZE_SEC   snooze duration in seconds (1..1023)
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-low
//   sec_tick    one-cycle pulse per second
//   cur_hour    current hour   (0..23)
//   cur_min     current minute (0..59)
//   cur_sec     current second (0..59)
//   alarm_en    alarm armed (level)
//   alarm_hour  alarm hour     (0..23)
//   alarm_min   alarm minute   (0..59)
//   snooze      snooze request pulse
//   stop        stop request pulse
//   set         one-cycle pulse, starts one tone on the alert player
//   ringing     high while ringing
//   snoozed     high while snoozed
//   beep_count  set pulses issued in the current ring episode
// ---------------------------------------------------------------------------
module alarm_sequencer #(
    parameter int unsigned BEEP_PERIOD = 2,
    parameter int unsigned MAX_BEEPS   = 10,
    parameter int unsigned SNOOZE_SEC  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       snooze,
    input  logic       stop,
    output logic       set,
    output logic       ringing,
    output logic       snoozed,
    output logic [3:0] beep_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [4:0] PERIOD = 5'(BEEP_PERIOD);
    localparam logic [3:0] MAXB   = 4'(MAX_BEEPS);
    localparam logic [9:0] SNZ    = 10'(SNOOZE_SEC);

    state_t     state_q, state_d;
    logic [3:0] sec_cnt_q, sec_cnt_d;
    logic [9:0] snz_cnt_q, snz_cnt_d;
    logic [3:0] beep_q, beep_d;
    logic       set_q, set_d;
    logic       ringing_q, snoozed_q;

    logic       time_match;
    logic [4:0] sec_next;

    // Only the tick at second 0 of the alarm minute matches, so each
    // matching minute triggers at most once.
    assign time_match = sec_tick && alarm_en && (cur_sec == 6'd0) &&
                        (cur_hour == alarm_hour) && (cur_min == alarm_min);

    // One bit wider than the counter so the compare is safe at PERIOD=15.
    assign sec_next = {1'b0, sec_cnt_q} + {4'd0, sec_tick};

    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        snz_cnt_d = snz_cnt_q;
        beep_d    = beep_q;
        set_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (time_match) begin
                    state_d   = RING;
                    set_d     = 1'b1;
                    beep_d    = 4'd1;
                    sec_cnt_d = '0;
                    snz_cnt_d = '0;
                end
            end

            RING: begin
                if (!alarm_en || stop) begin
                    state_d   = IDLE;
                    sec_cnt_d = '0;
                    snz_cnt_d = '0;
                    beep_d    = '0;
                end else if (snooze) begin
                    state_d   = SNOOZE;
                    sec_cnt_d = '0;
                    snz_cnt_d = '0;
                    beep_d    = '0;
                end else if (sec_next >= PERIOD) begin
                    if (beep_q >= MAXB) begin
                        state_d   = IDLE;
                        sec_cnt_d = '0;
                        beep_d    = '0;
                    end else if (set_q) begin
                        // A pulse is already out this cycle; hold the period
                        // as elapsed so the beep fires one cycle later rather
                        // than back-to-back.
                        sec_cnt_d = PERIOD[3:0];
                    end else begin
                        sec_cnt_d = '0;
                        set_d     = 1'b1;
                        beep_d    = beep_q + 4'd1;
                    end
                end else begin
                    sec_cnt_d = sec_next[3:0];
                end
            end

            SNOOZE: begin
                if (!alarm_en || stop) begin
                    state_d   = IDLE;
                    sec_cnt_d = '0;
                    snz_cnt_d = '0;
                    beep_d    = '0;
                end else if (sec_tick) begin
                    if (snz_cnt_q + 10'd1 == SNZ) begin
                        state_d   = RING;
                        set_d     = 1'b1;
                        beep_d    = 4'd1;
                        sec_cnt_d = '0;
                        snz_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 10'd1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                sec_cnt_d = '0;
                snz_cnt_d = '0;
                beep_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sec_cnt_q <= '0;
            snz_cnt_q <= '0;
            beep_q    <= '0;
            set_q     <= 1'b0;
            ringing_q <= 1'b0;
            snoozed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
            snz_cnt_q <= snz_cnt_d;
            beep_q    <= beep_d;
            set_q     <= set_d;
            ringing_q <= (state_d == RING);
            snoozed_q <= (state_d == SNOOZE);
        end
    end

    assign set        = set_q;
    assign ringing    = ringing_q;
    assign snoozed    = snoozed_q;
    assign beep_count = beep_q;

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter BEEP_PERIOD, default 2, seconds between successive set pulses while ringing (1..15).
REQ-002 Parameter MAX_BEEPS, default 10, set pulses per ring episode before auto-timeout (1..15).
REQ-003 Parameter SNOOZE_SEC, default 300, snooze duration in seconds (1..1023).
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 sec_tick  input  1  one-cycle pulse, one per second, from the time-keeping stage.
REQ-007 cur_hour  input  5  current hour, 0..23.
REQ-008 cur_min  input  6  current minute, 0..59.
REQ-009 cur_sec  input  6  current second, 0..59.
REQ-010 alarm_en  input  1  level; alarm armed when high.
REQ-011 alarm_hour  input  5  alarm hour, 0..23.
REQ-012 alarm_min  input  6  alarm minute, 0..59.
REQ-013 snooze  input  1  one-cycle request pulse (debounced upstream).
REQ-014 stop  input  1  one-cycle request pulse (debounced upstream).
REQ-015 set  output  1  one-cycle pulse to the alert player's set input; each pulse starts one tone.
REQ-016 ringing  output  1  high while in RING.
REQ-017 snoozed  output  1  high while in SNOOZE.
REQ-018 beep_count  output  4  set pulses issued in the current ring episode.

Function
REQ-019 States IDLE, RING, SNOOZE; all outputs registered.
REQ-020 Trigger: in IDLE, on a cycle with sec_tick=1, alarm_en=1, cur_sec=0, cur_hour=alarm_hour, cur_min=alarm_min -> RING next cycle; exactly one trigger per matching minute.
REQ-021 Entering RING: set=1 in the first RING cycle, beep_count=1, seconds counter cleared.
REQ-022 In RING: seconds counter increments on each sec_tick; when it reaches BEEP_PERIOD it clears and, if beep_count<MAX_BEEPS, set pulses next cycle and beep_count increments.
REQ-023 In RING with beep_count=MAX_BEEPS, the BEEP_PERIOD-th sec_tick moves to IDLE with no set pulse.
REQ-024 snooze in RING -> SNOOZE next cycle, snooze counter cleared, beep_count cleared, no set pulse.
REQ-025 In SNOOZE: snooze counter (10 bits) increments per sec_tick; at SNOOZE_SEC -> RING with REQ-021 entry behaviour.
REQ-026 stop in RING or SNOOZE -> IDLE next cycle; beep_count and counters cleared.
REQ-027 alarm_en=0 in any state -> IDLE next cycle; no set pulse in that cycle.
REQ-028 Priority on the same cycle: alarm_en=0 > stop > snooze > sec_tick-driven actions.
REQ-029 snooze or stop in IDLE ignored; snooze in SNOOZE ignored (no restart of snooze timer).
REQ-030 Time match while in RING or SNOOZE ignored.
REQ-031 set never high on two consecutive cycles; set high only in RING.
REQ-032 sec_tick coincident with set-causing transition is not lost: counters use registered next-state values.

Reset
REQ-033 rst=0 asynchronously forces IDLE, set=0, ringing=0, snoozed=0, beep_count=0, all counters 0.
REQ-034 Reset mid-RING or mid-SNOOZE aborts the episode; after rst returns high, no trigger until the next matching minute with sec_tick.
REQ-035 Reset deassertion takes effect on the first clk rising edge after rst goes high.

Verification
REQ-036 alarm 07:30, en=1, tick at 07:30:00 -> set pulse next cycle, ringing=1, beep_count=1; further pulses at ticks 07:30:02, :04...; 10 pulses total, IDLE at tick 07:30:20.
REQ-037 Ringing, snooze at beep_count=3 -> snoozed=1, beep_count=0, no set; 300 ticks later -> RING, set pulse, beep_count=1.
REQ-038 Ringing, stop and snooze same cycle -> IDLE, no set; repeated ticks 07:30:01..07:30:59 -> no re-trigger.
REQ-039 In SNOOZE, alarm_en dropped -> IDLE next cycle, snoozed=0; en restored at 07:31 -> no trigger.
REQ-040 alarm 23:59, ticks through 23:59:00 with en=0 -> no set; en=1 at 00:00 next day 23:59:00 -> triggers.
REQ-041 rst pulsed low mid-RING at beep_count=5 -> all outputs 0 immediately, without a clk edge.
